// File: rtl/sub_result_stage.sv
// Result stage behind the W-bit subtractor: 2-entry buffered valid/ready stage deriving Z/N/V/BRW flags.
// Optional self-check of the subtractor result is enabled by defining SUB_RESULT_CHECK_EN.
module sub_result_stage #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_sum,
   input  logic         in_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_diff,
   output logic [3:0]   out_flags,
   output logic         chk_err
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // Status flags {Z, N, V, BRW}; B==0 yields Cout=0 from the subtractor without a real borrow.
   function automatic logic [3:0] f_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] s, input logic c);
      logic z, n, v, brw;
      z   = (s == {W{1'b0}});
      n   = s[W-1];
      v   = (a[W-1] != b[W-1]) & (s[W-1] != a[W-1]);
      brw = (b == {W{1'b0}}) ? 1'b0 : ~c;
      f_flags = {z, n, v, brw};
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W+3:0]   r_mem [2];
   logic           r_head;
   logic           r_tail;
   logic           r_in_ready;
   logic           r_out_valid;
   logic [W-1:0]   r_out_diff;
   logic [3:0]     r_out_flags;
   logic           w_push;
   logic           w_pop;
   logic           w_load_new;
   logic           w_load_mem;
   logic [W+3:0]   w_entry;

   assign w_push  = in_valid & r_in_ready;
   assign w_pop   = r_out_valid & out_ready;
   assign w_entry = {in_sum, f_flags(in_a, in_b, in_sum, in_cout)};

   // Occupancy next state and selection of what becomes the head next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_load_new  = 1'b0;
      w_load_mem  = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt = S_ONE;
               w_load_new  = 1'b1;
            end else begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_ONE: begin
            if (w_push && !w_pop) begin
               w_state_nxt = S_FULL;
            end else if (w_pop && !w_push) begin
               w_state_nxt = S_EMPTY;
            end else if (w_push && w_pop) begin
               w_state_nxt = S_ONE;
               w_load_new  = 1'b1;
            end else begin
               w_state_nxt = S_ONE;
            end
         end
         S_FULL: begin
            if (w_pop) begin
               w_state_nxt = S_ONE;
               w_load_mem  = 1'b1;
            end else begin
               w_state_nxt = S_FULL;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

   // Occupancy state, pointers, storage and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_head      <= 1'b0;
         r_tail      <= 1'b0;
         r_mem[0]    <= {(W+4){1'b0}};
         r_mem[1]    <= {(W+4){1'b0}};
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_diff  <= {W{1'b0}};
         r_out_flags <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != S_FULL);
         r_out_valid <= (w_state_nxt != S_EMPTY);
         if (w_push) begin
            r_mem[r_tail] <= w_entry;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         // Head only changes on a new head; otherwise the last popped value is retained.
         if (w_load_new) begin
            r_out_diff  <= w_entry[W+3:4];
            r_out_flags <= w_entry[3:0];
         end else if (w_load_mem) begin
            r_out_diff  <= r_mem[~r_head][W+3:4];
            r_out_flags <= r_mem[~r_head][3:0];
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_diff  = r_out_diff;
   assign out_flags = r_out_flags;

`ifdef SUB_RESULT_CHECK_EN
   logic [W-1:0] w_neg_b;
   logic [W:0]   w_exp_add;
   logic [W-1:0] w_exp_sum;
   logic         w_mismatch;
   logic         r_chk_err;

   assign w_neg_b    = ~in_b + {{(W-1){1'b0}}, 1'b1};
   assign w_exp_add  = {1'b0, in_a} + {1'b0, w_neg_b};
   assign w_exp_sum  = in_a - in_b;
   assign w_mismatch = (in_sum != w_exp_sum) | (in_cout != w_exp_add[W]);

   // Sticky error on any pushed result that disagrees with recomputed arithmetic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk_err <= 1'b0;
      end else if (w_push && w_mismatch) begin
         r_chk_err <= 1'b1;
      end
   end

   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Randomised self-checking bench for sub_result_stage against a queue-based reference model.
module tb_sub_result_stage;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] in_sum = '0;
   logic         in_cout = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_diff;
   logic [3:0]   out_flags;
   logic         chk_err;

   int n_vec = 0;
   int n_err = 0;

   sub_result_stage #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_flags(out_flags), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Flags from plain integer arithmetic: {Z, N, V, BRW}
   function automatic logic [3:0] m_flags(input int a, input int b, input int s, input int c);
      int sa, sb, sd;
      logic z, n, v, brw;
      sa  = (a >= 8) ? a - 16 : a;
      sb  = (b >= 8) ? b - 16 : b;
      sd  = sa - sb;
      z   = (s == 0);
      n   = (s >= 8);
      v   = (sd > 7) || (sd < -8);
      brw = (b != 0) && (c == 0);
      return {z, n, v, brw};
   endfunction

   typedef struct { logic [W-1:0] d; logic [3:0] f; } ent_t;
   ent_t         q[$];
   logic [W-1:0] last_d = '0;
   logic [3:0]   last_f = '0;
   logic         m_err = 1'b0;

   // Reference model state update
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         last_d = '0;
         last_f = '0;
         m_err  = 1'b0;
      end else begin
         bit   push, pop;
         ent_t e;
         push = in_valid && (q.size() < 2);
         pop  = out_ready && (q.size() > 0);
         if (pop) begin
            e      = q.pop_front();
            last_d = e.d;
            last_f = e.f;
         end
         if (push) begin
            e.d = in_sum;
            e.f = m_flags(int'(in_a), int'(in_b), int'(in_sum), int'(in_cout));
            q.push_back(e);
`ifdef SUB_RESULT_CHECK_EN
            if (int'(in_sum) != ((int'(in_a) - int'(in_b)) & 15) ||
                int'(in_cout) != ((int'(in_a) + ((16 - int'(in_b)) & 15)) >= 16 ? 1 : 0))
               m_err = 1'b1;
`endif
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against model every cycle, away from the rising edge
   always @(negedge clk) begin
      logic [W-1:0] ed;
      logic [3:0]   ef;
      ed = (q.size() > 0) ? q[0].d : last_d;
      ef = (q.size() > 0) ? q[0].f : last_f;
      check("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      check("in_ready",  int'(in_ready),  (q.size() < 2) ? 1 : 0);
      check("out_diff",  int'(out_diff),  int'(ed));
      check("out_flags", int'(out_flags), int'(ef));
      check("chk_err",   int'(chk_err),   int'(m_err));
   end

   task automatic drive(input int a, input int b, input int s, input int c);
      in_valid = 1'b1;
      in_a     = a[W-1:0];
      in_b     = b[W-1:0];
      in_sum   = s[W-1:0];
      in_cout  = c[0];
   endtask

   task automatic drive_rand();
      int a, b;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      drive(a, b, (a - b) & 15, ((a + ((16 - b) & 15)) >= 16) ? 1 : 0);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      // Pin the model on hand-computed flag values
      check("model_5_3",  int'(m_flags(5, 3, 2, 1)),   4'b0000);
      check("model_3_5",  int'(m_flags(3, 5, 14, 0)),  4'b0101);
      check("model_9_9",  int'(m_flags(9, 9, 0, 1)),   4'b1000);
      check("model_7_8",  int'(m_flags(7, 8, 15, 0)),  4'b0111);
      check("model_6_0",  int'(m_flags(6, 0, 6, 0)),   4'b0000);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Directed vectors, each visible the cycle after its push
      @(negedge clk); drive(5, 3, 2, 1);
      @(negedge clk); in_valid = 1'b0;
      check("t1_diff", int'(out_diff), 2);  check("t1_flags", int'(out_flags), 4'b0000);
      drive(3, 5, 14, 0);
      @(negedge clk); drive(9, 9, 0, 1);
      check("t2a_diff", int'(out_diff), 14); check("t2a_flags", int'(out_flags), 4'b0101);
      @(negedge clk); drive(7, 8, 15, 0);
      check("t2b_flags", int'(out_flags), 4'b1000);
      @(negedge clk); drive(6, 0, 6, 0);
      check("t3a_flags", int'(out_flags), 4'b0111);
      @(negedge clk); in_valid = 1'b0;
      check("t3b_flags", int'(out_flags), 4'b0000);
      idle_cycle();
      check("retain_diff", int'(out_diff), 6);

      // Backpressure: three back-to-back offers, only two accepted
      out_ready = 1'b0;
      drive(1, 2, 15, 0);
      @(negedge clk); drive(4, 1, 3, 1);
      @(negedge clk); drive(8, 1, 7, 1);
      check("bp_ready", int'(in_ready), 0);
      repeat (3) @(negedge clk);
      check("bp_head", int'(out_diff), 15);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Continuous streaming
      for (int i = 0; i < 16; i++) begin
         drive_rand();
         @(negedge clk);
      end
      in_valid = 1'b0;

      // Random valid/ready mix
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) drive_rand(); else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end

      // Reset while FULL
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk); drive_rand();
      @(negedge clk); drive_rand();
      @(negedge clk); in_valid = 1'b0;
      check("full_ready", int'(in_ready), 0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_ready", int'(in_ready), 1);
      check("rst_diff",  int'(out_diff), 0);
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;

      // Corrupted result: 5-3 reported as 3
      @(negedge clk); drive(5, 3, 3, 1);
      @(negedge clk); in_valid = 1'b0;
`ifdef SUB_RESULT_CHECK_EN
      check("chk_set", int'(chk_err), 1);
`else
      check("chk_tied", int'(chk_err), 0);
`endif
      for (int i = 0; i < 20; i++) begin
         drive_rand();
         @(negedge clk);
      end
      in_valid = 1'b0;
`ifdef SUB_RESULT_CHECK_EN
      check("chk_sticky", int'(chk_err), 1);
`endif
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
